keypad_scanner: RTL
===================

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 100000: OSC_100MHz cycles each column is driven (1 ms).
REQ-002 Parameter DEBOUNCE_SCANS, default 4: consecutive identical full sweeps required to accept a key state.
REQ-003 Parameter REPEAT_DELAY, default 500: sweeps a key is held before the first auto-repeat event (KYPD_REPEAT_EN only).
REQ-004 Parameter REPEAT_RATE, default 100: sweeps between subsequent auto-repeat events (KYPD_REPEAT_EN only).
REQ-005 OSC_100MHz  in  1  system clock; all logic on its rising edge.
REQ-006 RST  in  1  reset; asynchronous, active-low.
REQ-007 KYPD_COL  out  4  active-low one-hot column drive.
REQ-008 KYPD_ROW  in  4  row sense, asynchronous, low = key closed on the driven column.
REQ-009 key_code  out  4  code of the last accepted key.
REQ-010 key_valid  out  1  event pending; held high until acknowledged.
REQ-011 key_ack  in  1  consumer acknowledge, sampled while key_valid=1.
REQ-012 key_held  out  1  high while the debounced state is a single key.
REQ-013 overrun  out  1  sticky: a press event was dropped while key_valid=1.

Function
REQ-014 KYPD_ROW SHALL pass through a 2-flop synchronizer before any use.
REQ-015 Column FSM COL0..COL3 SHALL drive KYPD_COL = 1110, 1101, 1011, 0111 respectively, advancing after SCAN_DIV cycles and wrapping COL3->COL0.
REQ-016 Synchronized rows SHALL be sampled on the last cycle (count SCAN_DIV-1) of each column period.
REQ-017 Key map (row r, col c): r0 = 1,2,3,A; r1 = 4,5,6,B; r2 = 7,8,9,C; r3 = 0,F,E,D; key_code SHALL be the label's hex value.
REQ-018 At end of COL3 sample, sweep result SHALL be the key if exactly one closure was seen in the sweep, else NONE (zero or multiple closures).
REQ-019 Stable counter SHALL increment (saturating at DEBOUNCE_SCANS) when the sweep result equals the previous sweep's, else load 1.
REQ-020 Debounced state SHALL update to the sweep result when the counter reaches DEBOUNCE_SCANS.
REQ-021 Press event SHALL occur when debounced state changes to a key from NONE or from a different key; change to NONE is not an event.
REQ-022 On an event with key_valid=0: key_code<=key, key_valid<=1 on the cycle after the completing sweep's final sample.
REQ-023 On an event with key_valid=1 and no key_ack that cycle: event dropped, key_code unchanged, overrun<=1.
REQ-024 key_ack with key_valid=1 and no event SHALL clear key_valid and overrun next cycle.
REQ-025 key_ack and event in the same cycle: event wins; key_valid stays 1, key_code updated, overrun cleared.
REQ-026 key_ack while key_valid=0 SHALL be ignored.
REQ-027 key_held SHALL equal (debounced state != NONE), updated with the debounced state.

Reset
REQ-028 RST low SHALL asynchronously force: column FSM COL0, KYPD_COL=1110, all counters 0, synchronizer flops 1, debounced state NONE, key_code=0, key_valid=0, key_held=0, overrun=0.
REQ-029 Reset asserted mid-sweep or with an event pending SHALL discard all partial debounce and pending event state.

Configuration
REQ-030 Macro KYPD_REPEAT_EN defined: while one key stays debounced, an extra press event with the same code SHALL fire after REPEAT_DELAY sweeps, then every REPEAT_RATE sweeps, following REQ-022..025; repeat counter clears on any debounced change.
REQ-031 KYPD_REPEAT_EN undefined: exactly one event per debounced press; REPEAT_DELAY/REPEAT_RATE unused, no repeat logic synthesized.

Verification (SCAN_DIV=4, DEBOUNCE_SCANS=2; sweep = 16 cycles)
REQ-032 Assert RST=0 mid-COL2 -> KYPD_COL=1110, key_valid=0, key_code=0, overrun=0 immediately.
REQ-033 Hold row1 low during COL1 for 3 sweeps -> key_valid=1, key_code=4'h5 after sweep 2; key_held=1; release 2 sweeps -> key_held=0, no second event.
REQ-034 Key 9 closed on alternate sweeps only -> key_valid never asserts.
REQ-035 Keys 1 and 2 held together 4 sweeps -> no event, key_held=0.
REQ-036 Press 1 (no ack), release, press 2 -> key_code=4'h1, overrun=1; key_ack pulse -> key_valid=0, overrun=0.
REQ-037 With KYPD_REPEAT_EN, REPEAT_DELAY=3, REPEAT_RATE=2, hold 0 and ack each event -> events after sweeps 2, 5, 7, 9, all key_code=4'h0.

Source files
------------

// File: rtl/keypad_scanner.sv
// keypad_scanner -- 4x4 matrix keypad scanner with debounce and a one-deep event latch.
//
// Columns are driven active-low one at a time for SCAN_DIV clocks each. The
// synchronized rows are sampled on the last clock of every column period. A
// sweep (COL0..COL3) resolves to a single key or NONE. A key state is accepted
// once DEBOUNCE_SCANS consecutive sweeps agree. A new accepted key raises
// key_valid, which stays high until the consumer acknowledges it.
//
// Optional feature: define KYPD_REPEAT_EN to add auto-repeat events while a key
// stays held. The first repeat comes after REPEAT_DELAY sweeps and later ones
// every REPEAT_RATE sweeps. Without the macro no repeat logic is built.
//
// Ports:
//   OSC_100MHz  in   system clock, rising edge
//   RST         in   asynchronous active-low reset
//   KYPD_COL    out  [3:0] active-low one-hot column drive
//   KYPD_ROW    in   [3:0] row sense, low = closed on the driven column (async)
//   key_code    out  [3:0] code of the last accepted key
//   key_valid   out  event pending, held until key_ack
//   key_ack     in   consumer acknowledge
//   key_held    out  debounced state is a single key
//   overrun     out  sticky: a press event was dropped while key_valid=1
module keypad_scanner #(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_DELAY   = 500,
  parameter int REPEAT_RATE    = 100
) (
  input  logic       OSC_100MHz,
  input  logic       RST,
  output logic [3:0] KYPD_COL,
  input  logic [3:0] KYPD_ROW,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       key_held,
  output logic       overrun
);
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int STB_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [STB_W-1:0] STB_MAX  = STB_W'(DEBOUNCE_SCANS);

  generate
    if (SCAN_DIV < 1 || DEBOUNCE_SCANS < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_params
      $error("keypad_scanner: all parameters must be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {COL0 = 2'd0, COL1 = 2'd1, COL2 = 2'd2, COL3 = 2'd3} col_state_t;
  col_state_t r_state, w_state_next;

  logic [DIV_W-1:0] r_div_cnt;
  logic [3:0]       r_row_meta, r_row_sync;
  logic [1:0]       r_hits;          // closures so far this sweep: 0, 1, or 2 meaning "several"
  logic [3:0]       r_hit_key;       // code of the first closure seen this sweep
  logic [4:0]       r_prev_result;   // {key present, code}; 5'h00 is NONE
  logic [4:0]       r_deb;           // debounced state, same encoding
  logic [STB_W-1:0] r_stable_cnt;
  logic [3:0]       r_key_code;
  logic             r_key_valid, r_overrun;

  logic             w_sample, w_sweep_end;
  logic [3:0]       w_col_closed, w_col_key, w_single_key;
  logic [2:0]       w_col_hits, w_hits_sum;
  logic [4:0]       w_sweep_result;
  logic [STB_W-1:0] w_stable_next;
  logic             w_deb_load, w_deb_change, w_press_event, w_event;
  logic [3:0]       w_event_key;

  function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
      4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
      4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
      4'hC: code = 4'h0;  4'hD: code = 4'hF;  4'hE: code = 4'hE;  default: code = 4'hD;
    endcase
    return code;
  endfunction

  // Row synchronizer; idle value is "no key" (all high).
  always_ff @(posedge OSC_100MHz or negedge RST) begin
    if (!RST) begin
      r_row_meta <= 4'hF;
      r_row_sync <= 4'hF;
    end else begin
      r_row_meta <= KYPD_ROW;
      r_row_sync <= r_row_meta;
    end
  end

  assign w_sample    = (r_div_cnt == DIV_LAST);
  assign w_sweep_end = w_sample && (r_state == COL3);

  always_ff @(posedge OSC_100MHz or negedge RST) begin
    if (!RST) begin
      r_state   <= COL0;
      r_div_cnt <= '0;
    end else begin
      r_state   <= w_state_next;
      r_div_cnt <= w_sample ? '0 : r_div_cnt + 1'b1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    KYPD_COL     = 4'b1110;
    case (r_state)
      COL0: begin KYPD_COL = 4'b1110; if (w_sample) w_state_next = COL1; end
      COL1: begin KYPD_COL = 4'b1101; if (w_sample) w_state_next = COL2; end
      COL2: begin KYPD_COL = 4'b1011; if (w_sample) w_state_next = COL3; end
      default: begin KYPD_COL = 4'b0111; if (w_sample) w_state_next = COL0; end
    endcase
  end

  // Closures on the current column. Which row supplies w_col_key only matters
  // when it is the sole closure of the sweep.
  assign w_col_closed = ~r_row_sync;
  assign w_col_hits   = 3'(w_col_closed[0]) + 3'(w_col_closed[1])
                      + 3'(w_col_closed[2]) + 3'(w_col_closed[3]);

  always_comb begin
    w_col_key = 4'h0;
    for (int r = 3; r >= 0; r--) begin
      if (w_col_closed[r]) w_col_key = key_lookup(2'(r), r_state);
    end
  end

  // The COL3 sample is folded in combinationally so the sweep result is known
  // on the final sample cycle itself.
  assign w_hits_sum     = {1'b0, r_hits} + w_col_hits;
  assign w_single_key   = (r_hits == 2'd0) ? w_col_key : r_hit_key;
  assign w_sweep_result = (w_hits_sum == 3'd1) ? {1'b1, w_single_key} : 5'h00;

  always_ff @(posedge OSC_100MHz or negedge RST) begin
    if (!RST) begin
      r_hits    <= 2'd0;
      r_hit_key <= 4'h0;
    end else if (w_sample) begin
      if (w_sweep_end) begin
        r_hits    <= 2'd0;
        r_hit_key <= 4'h0;
      end else begin
        r_hits <= (w_hits_sum >= 3'd2) ? 2'd2 : w_hits_sum[1:0];
        if (r_hits == 2'd0) r_hit_key <= w_col_key;
      end
    end
  end

  always_comb begin
    if (w_sweep_result == r_prev_result)
      w_stable_next = (r_stable_cnt == STB_MAX) ? STB_MAX : r_stable_cnt + 1'b1;
    else
      w_stable_next = STB_W'(1);
  end

  assign w_deb_load    = (w_stable_next == STB_MAX);
  assign w_deb_change  = w_sweep_end && w_deb_load && (w_sweep_result != r_deb);
  assign w_press_event = w_deb_change && w_sweep_result[4];

  always_ff @(posedge OSC_100MHz or negedge RST) begin
    if (!RST) begin
      r_prev_result <= 5'h00;
      r_stable_cnt  <= '0;
      r_deb         <= 5'h00;
    end else if (w_sweep_end) begin
      r_prev_result <= w_sweep_result;
      r_stable_cnt  <= w_stable_next;
      if (w_deb_load) r_deb <= w_sweep_result;
    end
  end

`ifdef KYPD_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int REP_W   = $clog2(REP_MAX + 1);

  logic [REP_W-1:0] r_rep_cnt, w_rep_inc;
  logic             r_rep_phase;   // 0: waiting for first repeat, 1: steady repeat
  logic             w_rep_fire;

  assign w_rep_inc  = r_rep_cnt + 1'b1;
  assign w_rep_fire = w_sweep_end && !w_deb_change && r_deb[4] &&
                      (r_rep_phase ? (w_rep_inc == REP_W'(REPEAT_RATE))
                                   : (w_rep_inc == REP_W'(REPEAT_DELAY)));

  always_ff @(posedge OSC_100MHz or negedge RST) begin
    if (!RST) begin
      r_rep_cnt   <= '0;
      r_rep_phase <= 1'b0;
    end else if (w_sweep_end) begin
      if (w_deb_change || !r_deb[4]) begin
        r_rep_cnt   <= '0;
        r_rep_phase <= 1'b0;
      end else if (w_rep_fire) begin
        r_rep_cnt   <= '0;
        r_rep_phase <= 1'b1;
      end else begin
        r_rep_cnt <= w_rep_inc;
      end
    end
  end

  assign w_event     = w_press_event || w_rep_fire;
  assign w_event_key = w_press_event ? w_sweep_result[3:0] : r_deb[3:0];
`else
  assign w_event     = w_press_event;
  assign w_event_key = w_sweep_result[3:0];
`endif

  // A new event outranks a same-cycle acknowledge.
  always_ff @(posedge OSC_100MHz or negedge RST) begin
    if (!RST) begin
      r_key_code  <= 4'h0;
      r_key_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else if (w_event) begin
      if (!r_key_valid) begin
        r_key_code  <= w_event_key;
        r_key_valid <= 1'b1;
      end else if (key_ack) begin
        r_key_code <= w_event_key;
        r_overrun  <= 1'b0;
      end else begin
        r_overrun <= 1'b1;
      end
    end else if (r_key_valid && key_ack) begin
      r_key_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end
  end

  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;
  assign overrun   = r_overrun;
  assign key_held  = r_deb[4];

endmodule
